// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the VRAM write port (m0 rasterizer, m1 fill engine) plus buffer-swap sequencing.
// Request in IDLE -> vram_sel_o next cycle; grant held until vram_ack_i, one idle bubble after; requesters hold sel until ack.
module vram_write_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  m0_sel_i,
  input  logic                  m0_wr_i,
  input  logic [MASK_WIDTH-1:0] m0_mask_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_ack_o,
  input  logic                  m1_sel_i,
  input  logic                  m1_wr_i,
  input  logic [MASK_WIDTH-1:0] m1_mask_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_ack_o,
  input  logic                  vram_ack_i,
  output logic                  vram_sel_o,
  output logic                  vram_wr_o,
  output logic [MASK_WIDTH-1:0] vram_mask_o,
  output logic [ADDR_WIDTH-1:0] vram_addr_o,
  output logic [DATA_WIDTH-1:0] vram_data_out_o,
  input  logic                  swap_req_i,
  output logic                  swap_o,
  output logic                  busy_o
);

  typedef struct packed {
    logic                  wr;
    logic [MASK_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, SWAP} state_t;

  state_t state;
  logic   last_grant;
  logic   swap_pending;
  req_t   req0;
  req_t   req1;
  req_t   vram_req;

  assign req0 = {m0_wr_i, m0_mask_i, m0_addr_i, m0_data_i};
  assign req1 = {m1_wr_i, m1_mask_i, m1_addr_i, m1_data_i};

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      swap_pending <= 1'b0;
      vram_sel_o   <= 1'b0;
      vram_req     <= '0;
      swap_o       <= 1'b0;
    end else begin
      swap_o <= 1'b0;
      if (swap_req_i)
        swap_pending <= 1'b1;
      case (state)
        IDLE: begin
          // A pending swap beats any new grant so the swap lands between transfers.
          if (swap_pending) begin
            state  <= SWAP;
            swap_o <= 1'b1;
          end else if (m0_sel_i && (!m1_sel_i || last_grant)) begin
            state      <= GRANT0;
            vram_sel_o <= 1'b1;
            vram_req   <= req0;
            last_grant <= 1'b0;
          end else if (m1_sel_i) begin
            state      <= GRANT1;
            vram_sel_o <= 1'b1;
            vram_req   <= req1;
            last_grant <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (vram_ack_i) begin
            vram_sel_o <= 1'b0;
            state      <= IDLE;
          end
        end
        SWAP: begin
          // A request arriving in the swap cycle itself re-arms for a second swap.
          swap_pending <= swap_req_i;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vram_wr_o       = vram_req.wr;
  assign vram_mask_o     = vram_req.mask;
  assign vram_addr_o     = vram_req.addr;
  assign vram_data_out_o = vram_req.data;

  assign m0_ack_o = vram_ack_i && (state == GRANT0);
  assign m1_ack_o = vram_ack_i && (state == GRANT1);
  assign busy_o   = (state != IDLE) || swap_pending;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: expected transfers queued at request time, checked at each VRAM ack.
module tb_vram_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        m0_sel_i, m0_wr_i, m1_sel_i, m1_wr_i;
  logic [3:0]  m0_mask_i, m1_mask_i;
  logic [15:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_ack_o, m1_ack_o;
  logic        vram_ack_i, vram_sel_o, vram_wr_o;
  logic [3:0]  vram_mask_o;
  logic [15:0] vram_addr_o, vram_data_out_o;
  logic        swap_req_i, swap_o, busy_o;

  vram_write_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(4)) dut (
    .clk(clk), .reset_i(reset_i),
    .m0_sel_i(m0_sel_i), .m0_wr_i(m0_wr_i), .m0_mask_i(m0_mask_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o),
    .m1_sel_i(m1_sel_i), .m1_wr_i(m1_wr_i), .m1_mask_i(m1_mask_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o),
    .vram_ack_i(vram_ack_i), .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o),
    .vram_mask_o(vram_mask_o), .vram_addr_o(vram_addr_o), .vram_data_out_o(vram_data_out_o),
    .swap_req_i(swap_req_i), .swap_o(swap_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic        wr;
    logic [3:0]  mask;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sel_cnt = 0;
  int   ack_dly = 2;
  bit   auto_ack = 1'b0;
  int   swap_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks the cycle just driven, advances one clock, then runs the VRAM responder.
  task automatic tick();
    exp_t e;
    #1;
    if (vram_ack_i && vram_sel_o) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("sb_ack_route", 32'({m1_ack_o, m0_ack_o}), e.id ? 32'd2 : 32'd1);
        check("sb_wr", 32'(vram_wr_o), 32'(e.wr));
        check("sb_mask", 32'(vram_mask_o), 32'(e.mask));
        check("sb_addr", 32'(vram_addr_o), 32'(e.addr));
        check("sb_data", 32'(vram_data_out_o), 32'(e.data));
      end
    end else begin
      check("no_ack", 32'({m1_ack_o, m0_ack_o}), 0);
    end
    @(posedge clk);
    #1;
    if (vram_sel_o) sel_cnt++;
    else sel_cnt = 0;
    if (swap_o) swap_cnt++;
    if (auto_ack) vram_ack_i = vram_sel_o && (sel_cnt == ack_dly);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    m0_sel_i = 1'b0; m1_sel_i = 1'b0; vram_ack_i = 1'b0; swap_req_i = 1'b0;
    auto_ack = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    sel_cnt = 0;
    swap_cnt = 0;
  endtask

  function automatic exp_t mk(input bit id);
    exp_t e;
    e.id   = id;
    e.wr   = id ? m1_wr_i : m0_wr_i;
    e.mask = id ? m1_mask_i : m0_mask_i;
    e.addr = id ? m1_addr_i : m0_addr_i;
    e.data = id ? m1_data_i : m0_data_i;
    return e;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    m0_wr_i = 1'b1; m0_mask_i = 4'hF; m0_addr_i = 16'h0040; m0_data_i = 16'hF800;
    m1_wr_i = 1'b0; m1_mask_i = 4'h3; m1_addr_i = 16'h1234; m1_data_i = 16'hABCD;

    // Reset state and single m0 transfer acked on its third grant cycle.
    do_reset();
    check("rst_sel", 32'(vram_sel_o), 0);
    check("rst_bus", 32'({vram_wr_o, vram_mask_o, vram_addr_o}), 0);
    check("rst_data", 32'(vram_data_out_o), 0);
    check("rst_swap_busy", 32'({swap_o, busy_o}), 0);
    m0_sel_i = 1'b1;
    exp_q.push_back(mk(1'b0));
    auto_ack = 1'b1; ack_dly = 3;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("t1_sel_c%0d", c), 32'(vram_sel_o), 1);
      check($sformatf("t1_addr_c%0d", c), 32'(vram_addr_o), 32'h0040);
      check($sformatf("t1_busy_c%0d", c), 32'(busy_o), 1);
    end
    tick();
    m0_sel_i = 1'b0;
    check("t1_sel_c4", 32'(vram_sel_o), 0);
    check("t1_empty", 32'(exp_q.size()), 0);

    // Both held: strict alternation starting with m0.
    do_reset();
    m0_sel_i = 1'b1; m1_sel_i = 1'b1;
    auto_ack = 1'b1; ack_dly = 2;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i[0]));
    drain("t2_done");
    m0_sel_i = 1'b0; m1_sel_i = 1'b0;
    tick();
    check("t2_idle_sel", 32'(vram_sel_o), 0);

    // Swap during an m1 grant lands before the waiting m0 grant.
    do_reset();
    m1_sel_i = 1'b1;
    exp_q.push_back(mk(1'b1));
    auto_ack = 1'b1; ack_dly = 3;
    tick();
    m0_sel_i = 1'b1; swap_req_i = 1'b1;
    exp_q.push_back(mk(1'b0));
    tick();
    swap_req_i = 1'b0;
    check("t3_busy", 32'(busy_o), 1);
    tick();
    tick();
    m1_sel_i = 1'b0;
    check("t3_idle_swap", 32'({vram_sel_o, swap_o}), 0);
    tick();
    check("t3_swap_cycle", 32'({vram_sel_o, swap_o}), 1);
    tick();
    check("t3_after_swap", 32'({vram_sel_o, swap_o}), 0);
    tick();
    check("t3_m0_sel", 32'(vram_sel_o), 1);
    check("t3_m0_addr", 32'(vram_addr_o), 32'h0040);
    drain("t3_done");
    m0_sel_i = 1'b0;
    tick();
    check("t3_swap_count", 32'(swap_cnt), 1);

    // Two requests in one grant merge; a request in the swap cycle re-arms.
    do_reset();
    m0_sel_i = 1'b1;
    exp_q.push_back(mk(1'b0));
    auto_ack = 1'b1; ack_dly = 4;
    tick();
    swap_req_i = 1'b1; tick();
    swap_req_i = 1'b0; tick();
    swap_req_i = 1'b1; tick();
    swap_req_i = 1'b0; tick();
    m0_sel_i = 1'b0;
    check("t4_idle_swap", 32'(swap_o), 0);
    tick();
    check("t4_swap1", 32'(swap_o), 1);
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
    check("t4_gap", 32'(swap_o), 0);
    tick();
    check("t4_swap2", 32'(swap_o), 1);
    tick();
    check("t4_quiet", 32'({swap_o, busy_o}), 0);
    check("t4_swap_count", 32'(swap_cnt), 2);

    // Reset in the middle of an unacked m0 grant.
    do_reset();
    m0_sel_i = 1'b1;
    tick();
    check("t5_sel", 32'(vram_sel_o), 1);
    tick();
    reset_i = 1'b1;
    tick();
    check("t5_rst_bus", 32'({vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o}), 0);
    check("t5_rst_data", 32'(vram_data_out_o), 0);
    check("t5_rst_misc", 32'({swap_o, busy_o, m1_ack_o, m0_ack_o}), 0);
    reset_i = 1'b0; m1_sel_i = 1'b1;
    tick();
    check("t5_regrant_addr", 32'(vram_addr_o), 32'h0040);
    exp_q.push_back(mk(1'b0));
    exp_q.push_back(mk(1'b1));
    auto_ack = 1'b1; ack_dly = 2;
    vram_ack_i = vram_sel_o && (sel_cnt == ack_dly);
    drain("t5_done");
    m0_sel_i = 1'b0; m1_sel_i = 1'b0;

    // Stray VRAM ack while idle.
    tick();
    auto_ack = 1'b0;
    vram_ack_i = 1'b1;
    tick();
    vram_ack_i = 1'b0;
    check("t6_idle", 32'({vram_sel_o, busy_o}), 0);
    tick();
    check("t6_still_idle", 32'({vram_sel_o, busy_o}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
